rib_arbiter: RTL and testbench



---
 rtl/rib_arbiter_pkg.sv | 20 ++
 rtl/rib_rr_picker.sv | 26 ++
 rtl/rib_arbiter.sv | 115 +++++++++++
 tb/tb_rib_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rib_arbiter_pkg.sv
// rib_arbiter_pkg: shared grant codes, arbiter state encodings and
// hold-flag levels for the RIB arbiter slice.
package rib_arbiter_pkg;

  typedef enum logic {
    RibArbIdle = 1'b0,
    RibArbBusy = 1'b1
  } rib_arb_state_e;

  localparam logic [1:0] Grant0 = 2'd0;
  localparam logic [1:0] Grant1 = 2'd1;
  localparam logic [1:0] Grant2 = 2'd2;
  localparam logic [1:0] Grant3 = 2'd3;

  localparam int RibArbTimeoutDefault = 16;

  localparam logic HoldEnable  = 1'b1;
  localparam logic HoldDisable = 1'b0;

endpackage

// File: rtl/rib_rr_picker.sv
// rib_rr_picker: combinational 4-way rotating priority picker.
// Ports: req[3:0], last[1:0] in; winner[1:0] (first set bit after last), any out.
module rib_rr_picker (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] idx;

  // Walk from the farthest candidate (last) back to the nearest
  // (last+1); the final hit is the highest-priority requester.
  always_comb begin
    winner = last;
    idx    = last;
    any    = |req;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: registered round-robin RIB bus arbiter with master 3
// priority and optional forced release (macro RIB_ARB_TIMEOUT_EN).
// Ports: clk, rst (sync, active-high), req_i[3:0], ack_i in;
// grant_o[1:0], grant_valid_o, hold_flag_o, timeout_o out.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = RibArbTimeoutDefault,
  parameter int M3_PRIO        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   ack_i,
  output logic [1:0]             grant_o,
  output logic                   grant_valid_o,
  output logic                   hold_flag_o,
  output logic                   timeout_o
);

  rib_arb_state_e state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic [1:0]     last_q, last_d;
  logic [1:0]     rr_win;
  logic [1:0]     win;
  logic           rr_any;
  logic           abort;
  logic           expire;
  logic           busy;

  rib_rr_picker u_pick (
    .req    (req_i),
    .last   (last_q),
    .winner (rr_win),
    .any    (rr_any)
  );

  assign busy  = (state_q == RibArbBusy);
  assign abort = ~req_i[grant_q];

  always_comb begin
    win = rr_win;
    if (M3_PRIO != 0 && req_i[3]) begin
      win = Grant3;
    end
  end

`ifdef RIB_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q;

  // Held at zero outside BUSY, so every grant starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expire = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  // Folds to 0; keeps TIMEOUT_CYCLES referenced in this build.
  assign expire = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // Ack and abort outrank expiry, so a simultaneous ack never pulses.
  assign timeout_o = busy & expire & ~ack_i & ~abort;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      RibArbIdle: begin
        if (rr_any) begin
          grant_d = win;
          state_d = RibArbBusy;
        end
      end
      RibArbBusy: begin
        if (ack_i | abort | expire) begin
          state_d = RibArbIdle;
          last_d  = grant_q;
        end
      end
      default: state_d = RibArbIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RibArbIdle;
      grant_q <= Grant1;
      last_q  <= Grant0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = busy;

  // Instruction fetch (master 1) alone never stalls the core.
  assign hold_flag_o =
    (req_i[0] | req_i[2] | req_i[3] |
     (busy & (grant_q != Grant1))) ? HoldEnable : HoldDisable;

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: scoreboard bench for rib_arbiter; expected grants
// are queued at request time and popped when a grant goes valid.
module tb_rib_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [1:0] grant;
  logic       gv;
  logic       hold;
  logic       to;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic gv_prev = 1'b0;

  rib_arbiter #(
    .NUM_MASTERS    (4),
    .TIMEOUT_CYCLES (16),
    .M3_PRIO        (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .ack_i         (ack),
    .grant_o       (grant),
    .grant_valid_o (gv),
    .hold_flag_o   (hold),
    .timeout_o     (to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // New grant: compare against the oldest queued expectation.
  always @(negedge clk) begin
    if (gv && !gv_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'(grant), 32'hFFFF_FFFF);
      end else begin
        chk("grant", 32'(grant), 32'(exp_q.pop_front()));
      end
    end
    gv_prev = gv;
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    ack = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
    mid();
    chk("rst_grant", 32'(grant), 1);
    chk("rst_gv", 32'(gv), 0);
    chk("rst_to", 32'(to), 0);
    chk("rst_hold", 32'(hold), 0);

    // single request from master 0, ack on 3rd BUSY cycle
    nxt();
    req = 4'b0001;
    exp_q.push_back(0);
    mid();
    chk("s_req_gv", 32'(gv), 0);
    chk("s_req_hold", 32'(hold), 1);
    for (int b = 1; b <= 3; b++) begin
      nxt();
      if (b == 3) ack = 1'b1;
      mid();
      chk("s_busy_gv", 32'(gv), 1);
      chk("s_busy_hold", 32'(hold), 1);
    end
    nxt();
    req = 4'b0000;
    ack = 1'b0;
    mid();
    chk("s_rel_gv", 32'(gv), 0);
    chk("s_rel_hold", 32'(hold), 0);

    // fairness: 1,2,0,1,2,0 with a bubble between each
    nxt();
    req = 4'b0111;
    ack = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(0);
    for (int i = 0; i < 12; i++) begin
      mid();
      chk("f_bubble", 32'(gv), 32'(i % 2));
      if (i < 11) nxt();
    end
    nxt();
    req = 4'b0000;
    ack = 1'b0;
    mid();
    chk("f_end_gv", 32'(gv), 0);

    // master 3 requests while master 1 is busy
    nxt();
    req = 4'b0010;
    exp_q.push_back(1);
    mid();
    nxt();
    req = 4'b1110;
    mid();
    chk("p_keep_grant", 32'(grant), 1);
    nxt();
    mid();
    chk("p_keep_grant2", 32'(grant), 1);
    chk("p_keep_gv", 32'(gv), 1);
    nxt();
    ack = 1'b1;
    mid();
    chk("p_ack_grant", 32'(grant), 1);
    nxt();
    ack = 1'b0;
    exp_q.push_back(3);
    mid();
    chk("p_idle_gv", 32'(gv), 0);
    nxt();
    mid();
    chk("p_m3_hold", 32'(hold), 1);
    nxt();
    req = 4'b0000;
    ack = 1'b1;
    mid();
    nxt();
    ack = 1'b0;
    mid();
    chk("p_end_gv", 32'(gv), 0);

    // master abort (last = 3, so master 0 wins)
    nxt();
    req = 4'b0001;
    exp_q.push_back(0);
    mid();
    nxt();
    mid();
    nxt();
    req = 4'b0000;
    mid();
    chk("a_abort_gv", 32'(gv), 1);
    chk("a_abort_to", 32'(to), 0);
    nxt();
    mid();
    chk("a_rel_gv", 32'(gv), 0);
    chk("a_rel_to", 32'(to), 0);

    // timeout: master 2, no ack (last = 0 -> 2 wins over nothing)
    nxt();
    req = 4'b0100;
    exp_q.push_back(2);
    mid();
    for (int b = 1; b <= 16; b++) begin
      nxt();
      mid();
      chk("t_busy_gv", 32'(gv), 1);
`ifdef RIB_ARB_TIMEOUT_EN
      chk("t_pulse", 32'(to), 32'(b == 16));
`else
      chk("t_pulse", 32'(to), 0);
`endif
    end
`ifndef RIB_ARB_TIMEOUT_EN
    nxt();
    mid();
    chk("t_stay_gv", 32'(gv), 1);
    nxt();
    req = 4'b0011;
    mid();
    chk("t_abort_to", 32'(to), 0);
`endif
    nxt();
    req = 4'b0011;
    exp_q.push_back(0);
    mid();
    chk("t_rel_gv", 32'(gv), 0);
    chk("t_rel_to", 32'(to), 0);
    nxt();
    mid();
    chk("t_next_gv", 32'(gv), 1);

    // reset in mid-BUSY
    nxt();
    rst = 1'b1;
    req = 4'b0000;
    mid();
    nxt();
    rst = 1'b0;
    mid();
    chk("r_grant", 32'(grant), 1);
    chk("r_gv", 32'(gv), 0);
    chk("r_to", 32'(to), 0);
    chk("r_hold", 32'(hold), 0);

    // pointer restored to 0 by reset: master 2 beats master 0
    nxt();
    req = 4'b0101;
    exp_q.push_back(2);
    mid();
    nxt();
    req = 4'b0000;
    mid();
    nxt();
    mid();
    chk("r_end_gv", 32'(gv), 0);

    chk("sb_left", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
